// File: rtl/pdm_clap_detector.sv
// PDM microphone front end for the clap counter: generates the mic clock,
// decimates the 1-bit stream into a per-window amplitude and turns loud
// windows into a single clap pulse aligned to one M_CLK rising edge.
module pdm_clap_detector #(
  parameter int CLK_DIV  = 25,
  parameter int WIN      = 128,
  parameter int THRESH   = 40,
  parameter int RELEASE  = 20,
  parameter int LOCK_WIN = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       M_DATA,
  output logic       M_CLK,
  output logic       M_LRSEL,
  output logic [6:0] amplitude_o,
  output logic       level_valid_o,
  output logic       clap_pulse_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WIN_W = (WIN > 1) ? $clog2(WIN) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOCKOUT,
    WAIT_QUIET
  } state_t;

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;
  logic             rise_tick;
  logic             fall_tick;

  logic [1:0]       sync_q;
  logic             sample;

  logic [WIN_W-1:0] sample_cnt;
  logic             last_sample;
  logic [7:0]       acc;
  logic [7:0]       ones_total;
  logic [6:0]       cnt7;
  logic [6:0]       amp7;

  state_t           state;
  logic [7:0]       lock_cnt;
  logic             pending;

  // Left channel only: the mic drives data while M_CLK is low-to-high.
  assign M_LRSEL = 1'b0;

  // The divider wrap marks the cycle right before M_CLK changes level.
  assign wrap      = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise_tick = wrap & ~M_CLK;
  assign fall_tick = wrap &  M_CLK;

  assign sample      = sync_q[1];
  assign last_sample = (sample_cnt == WIN_W'(WIN - 1));

  // Free-running M_CLK divider; M_CLK flips on every wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt <= '0;
      M_CLK   <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      M_CLK   <= ~M_CLK;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Two-flop synchroniser for the asynchronous mic data line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], M_DATA};
    end
  end

  // Window total including the current sample, saturated to 7 bits, folded
  // around the 50% density point (64) to give a 0..64 loudness value.
  always_comb begin
    ones_total = acc + {7'd0, sample};
    cnt7       = ones_total[7] ? 7'd127 : ones_total[6:0];
    amp7       = cnt7[6] ? (cnt7 - 7'd64) : (7'd64 - cnt7);
  end

  // Count ones over WIN rising-edge samples and publish one amplitude per window.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sample_cnt    <= '0;
      acc           <= 8'd0;
      amplitude_o   <= 7'd0;
      level_valid_o <= 1'b0;
    end else begin
      level_valid_o <= 1'b0;
      if (rise_tick) begin
        if (last_sample) begin
          sample_cnt    <= '0;
          acc           <= 8'd0;
          amplitude_o   <= amp7;
          level_valid_o <= 1'b1;
        end else begin
          sample_cnt <= sample_cnt + WIN_W'(1);
          acc        <= ones_total;
        end
      end
    end
  end

  // Clap FSM plus pulse shaper: detection sets pending, the pulse then spans
  // fall_tick to fall_tick so exactly one M_CLK rise lands inside it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      lock_cnt     <= 8'd0;
      pending      <= 1'b0;
      clap_pulse_o <= 1'b0;
    end else begin
      if (fall_tick) begin
        if (clap_pulse_o) begin
          clap_pulse_o <= 1'b0;
          pending      <= 1'b0;
        end else if (pending) begin
          clap_pulse_o <= 1'b1;
        end
      end

      if (level_valid_o) begin
        case (state)
          IDLE: begin
            if (amplitude_o >= 7'(THRESH)) begin
              pending  <= 1'b1;
              lock_cnt <= 8'(LOCK_WIN);
              state    <= LOCKOUT;
            end
          end
          LOCKOUT: begin
            if (lock_cnt <= 8'd1) begin
              lock_cnt <= 8'd0;
              state    <= WAIT_QUIET;
            end else begin
              lock_cnt <= lock_cnt - 8'd1;
            end
          end
          WAIT_QUIET: begin
            if (amplitude_o < 7'(RELEASE)) begin
              state <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
